// File: rtl/usb_pkt_rx_pkg.sv
// Shared USB receive constants: SYNC byte, PID codes and classes, CRC parameters,
// pkt_err bit positions and the receiver FSM state type.
package usb_pkt_rx_pkg;

  localparam logic [7:0] SyncByte = 8'h80;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSof   = 4'b0101;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidPing  = 4'b0100;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidData2 = 4'b0111;
  localparam logic [3:0] PidMdata = 4'b1111;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;
  localparam logic [3:0] PidNyet  = 4'b0110;
  localparam logic [3:0] PidStall = 4'b1110;

  localparam logic [4:0]  Crc5Poly  = 5'b00101;
  localparam logic [4:0]  Crc5Init  = 5'b11111;
  localparam logic [4:0]  Crc5Res   = 5'b01100;
  localparam logic [15:0] Crc16Poly = 16'h8005;
  localparam logic [15:0] Crc16Init = 16'hFFFF;
  localparam logic [15:0] Crc16Res  = 16'h800D;

  localparam int unsigned ErrSync = 0;
  localparam int unsigned ErrPid  = 1;
  localparam int unsigned ErrLen  = 2;
  localparam int unsigned ErrCrc  = 3;
  localparam int unsigned ErrOvf  = 4;

  typedef enum logic [1:0] {ClsNone, ClsToken, ClsData, ClsHshk} pid_cls_e;
  typedef enum logic [1:0] {StIdle, StPid, StBody, StDone} rx_state_e;

  function automatic pid_cls_e pid_class(input logic [3:0] pid);
    pid_cls_e cls;
    case (pid)
      PidOut, PidIn, PidSof, PidSetup, PidPing: cls = ClsToken;
      PidData0, PidData1, PidData2, PidMdata:   cls = ClsData;
      PidAck, PidNak, PidNyet, PidStall:        cls = ClsHshk;
      default:                                  cls = ClsNone;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/usb_pkt_rx_if.sv
// Packet receiver bus: usb_rx byte strobes in, packet result/handshake and buffer read port out.
interface usb_pkt_rx_if #(
  parameter int unsigned AW = 7
) ();
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          rx_eop;
  logic          pkt_valid;
  logic [3:0]    pkt_pid;
  logic [AW-1:0] pkt_len;
  logic [4:0]    pkt_err;
  logic          pkt_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          dropped;

  modport slave (
    input  rx_ready, rx_data, rx_eop, pkt_ack, rd_addr,
    output pkt_valid, pkt_pid, pkt_len, pkt_err, rd_data, dropped
  );

  modport master (
    output rx_ready, rx_data, rx_eop, pkt_ack, rd_addr,
    input  pkt_valid, pkt_pid, pkt_len, pkt_err, rd_data, dropped
  );
endinterface

// File: rtl/usb_crc_step.sv
// One byte of USB CRC5 and CRC16, fed LSB first, eight bit-steps in a single cycle.
module usb_crc_step
  import usb_pkt_rx_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [4:0]  crc5_in,
  input  logic [15:0] crc16_in,
  output logic [4:0]  crc5_out,
  output logic [15:0] crc16_out
);

  always_comb begin
    crc5_out  = crc5_in;
    crc16_out = crc16_in;
    for (int i = 0; i < 8; i++) begin
      crc5_out  = {crc5_out[3:0], 1'b0} ^ ((data[i] ^ crc5_out[4]) ? Crc5Poly : 5'b0);
      crc16_out = {crc16_out[14:0], 1'b0} ^ ((data[i] ^ crc16_out[15]) ? Crc16Poly : 16'h0);
    end
  end

endmodule

// File: rtl/usb_pkt_rx.sv
// USB packet receiver: checks SYNC/PID/CRC, buffers post-PID bytes and holds one
// packet result until the protocol layer acknowledges it.
module usb_pkt_rx
  import usb_pkt_rx_pkg::*;
#(
  parameter int unsigned AW        = 7,
  parameter int unsigned MAX_BYTES = 66
) (
  input logic         clk,
  input logic         rst_n,
  usb_pkt_rx_if.slave bus
);

  localparam logic [AW:0] CntMax = (AW + 1)'(MAX_BYTES);
  localparam logic [AW:0] CntOne = (AW + 1)'(1);
  localparam logic [AW:0] CntTwo = (AW + 1)'(2);

  rx_state_e     state_q, state_d, eff;
  logic [AW:0]   count_q, count_d;
  logic [4:0]    crc5_q, crc5_d, crc5_nxt;
  logic [15:0]   crc16_q, crc16_d, crc16_nxt;
  logic          store_q, store_d;
  logic          sync_err_q, sync_err_d, pid_err_q, pid_err_d, ovf_q, ovf_d;
  pid_cls_e      cls_q, cls_d;
  logic [3:0]    pid_q, pid_d;
  logic          valid_q, valid_d, dropped_q, dropped_d;
  logic [3:0]    opid_q, opid_d;
  logic [AW-1:0] olen_q, olen_d;
  logic [4:0]    oerr_q, oerr_d;
  logic          len_err, crc_err, we;
  logic [7:0]    mem [2**AW];

  usb_crc_step u_crc (
    .data      (bus.rx_data),
    .crc5_in   (crc5_q),
    .crc16_in  (crc16_q),
    .crc5_out  (crc5_nxt),
    .crc16_out (crc16_nxt)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    crc5_d     = crc5_q;
    crc16_d    = crc16_q;
    store_d    = store_q;
    sync_err_d = sync_err_q;
    pid_err_d  = pid_err_q;
    ovf_d      = ovf_q;
    cls_d      = cls_q;
    pid_d      = pid_q;
    valid_d    = valid_q;
    opid_d     = opid_q;
    olen_d     = olen_q;
    oerr_d     = oerr_q;
    dropped_d  = 1'b0;
    we         = 1'b0;
    len_err    = 1'b0;
    crc_err    = 1'b0;
    eff        = state_q;

    // Byte handling first; eff is the state the byte leaves us in, so a same-cycle
    // eop is evaluated against the post-byte view.
    unique case (state_q)
      StIdle: begin
        if (bus.rx_ready) begin
          count_d    = '0;
          crc5_d     = Crc5Init;
          crc16_d    = Crc16Init;
          pid_err_d  = 1'b0;
          ovf_d      = 1'b0;
          cls_d      = ClsNone;
          pid_d      = '0;
          sync_err_d = (bus.rx_data != SyncByte);
          store_d    = (bus.rx_data == SyncByte);
          eff        = (bus.rx_data == SyncByte) ? StPid : StBody;
        end
      end
      StPid: begin
        if (bus.rx_ready) begin
          pid_d     = bus.rx_data[3:0];
          cls_d     = pid_class(bus.rx_data[3:0]);
          pid_err_d = (bus.rx_data[7:4] != ~bus.rx_data[3:0]) || (cls_d == ClsNone);
          eff       = StBody;
        end
      end
      StBody: begin
        if (bus.rx_ready && store_q) begin
          if (count_q < CntMax) begin
            we      = 1'b1;
            count_d = count_q + CntOne;
          end else begin
            ovf_d = 1'b1;
          end
          crc5_d  = crc5_nxt;
          crc16_d = crc16_nxt;
        end
      end
      StDone: begin
        if (bus.rx_eop) dropped_d = 1'b1;
        if (bus.pkt_ack) begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StDone) begin
      state_d = eff;
      if (bus.rx_eop && eff != StIdle) begin
        len_err = (eff == StPid) ||
                  (cls_d == ClsToken && count_d != CntTwo) ||
                  (cls_d == ClsHshk && |count_d) ||
                  (cls_d == ClsData && count_d < CntTwo);
        crc_err = !len_err && ((cls_d == ClsToken && crc5_d != Crc5Res) ||
                               (cls_d == ClsData && crc16_d != Crc16Res));
        oerr_d  = {ovf_d, crc_err, len_err, pid_err_d, sync_err_d};
        opid_d  = pid_d;
        olen_d  = count_d[AW-1:0];
        valid_d = 1'b1;
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      count_q    <= '0;
      crc5_q     <= Crc5Init;
      crc16_q    <= Crc16Init;
      store_q    <= 1'b0;
      sync_err_q <= 1'b0;
      pid_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
      cls_q      <= ClsNone;
      pid_q      <= '0;
      valid_q    <= 1'b0;
      opid_q     <= '0;
      olen_q     <= '0;
      oerr_q     <= '0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      crc5_q     <= crc5_d;
      crc16_q    <= crc16_d;
      store_q    <= store_d;
      sync_err_q <= sync_err_d;
      pid_err_q  <= pid_err_d;
      ovf_q      <= ovf_d;
      cls_q      <= cls_d;
      pid_q      <= pid_d;
      valid_q    <= valid_d;
      opid_q     <= opid_d;
      olen_q     <= olen_d;
      oerr_q     <= oerr_d;
      dropped_q  <= dropped_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[count_q[AW-1:0]] <= bus.rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rd_data <= '0;
    else        bus.rd_data <= mem[bus.rd_addr];
  end

  assign bus.pkt_valid = valid_q;
  assign bus.pkt_pid   = opid_q;
  assign bus.pkt_len   = olen_q;
  assign bus.pkt_err   = oerr_q;
  assign bus.dropped   = dropped_q;

endmodule

// File: doc/usb_pkt_rx.md
Name: usb_pkt_rx

Overview:
Packet-level receiver directly downstream of usb_rx. Consumes its byte strobe (ready/data/eop) and checks SYNC, PID and CRC5/CRC16. Buffers the post-PID bytes and presents one packet at a time to the protocol layer through a valid/ack handshake and a random-access read port. It is the receive-side counterpart of the byte sequencer that feeds usb_tx.

Parameters:
AW, 7, buffer address width; buffer depth is 2**AW bytes.
MAX_BYTES, 66, maximum bytes stored after the PID (64 payload + 2 CRC). Must be ≤ 2**AW.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous assert, active low
rx_ready  in  1  one-cycle strobe: rx_data valid (usb_rx ready)
rx_data  in  8  received byte, LSB first on wire
rx_eop  in  1  one-cycle strobe: end of packet (usb_rx eop)
pkt_valid  out  1  packet result pending; held until acked
pkt_pid  out  4  PID[3:0] of pending packet
pkt_len  out  AW  count of stored bytes after PID, CRC bytes included
pkt_err  out  5  {ovf, crc, len, pid, sync}; all 0 = good packet
pkt_ack  in  1  consumer releases pending packet (level, sampled at posedge)
rd_addr  in  AW  buffer read address
rd_data  out  8  buffer byte; registered, valid 1 cycle after rd_addr
dropped  out  1  one-cycle pulse: packet discarded because one was pending

Behaviour:
- Reset: every output 0; state IDLE; CRC registers preset; byte count 0.
- States:
  - IDLE: rx_ready → check byte against `SYNC_BYTE; match → PID, mismatch → BODY with sync err set and storing disabled.
  - PID: next byte; pid err set unless rx_data[7:4] == ~rx_data[3:0]. Classify rx_data[3:0]:
    - token: 0001, 1001, 0101, 1101, 0100
    - data: 0011, 1011, 0111, 1111
    - handshake: 0010, 1010, 1110, 0110
    - 0000, 1000, 1100: pid err.
  - BODY: each rx_ready writes the byte at address count (if count < MAX_BYTES), increments count and updates both CRCs. A byte when count == MAX_BYTES sets ovf; the byte is not stored and count saturates.
  - rx_eop in PID or BODY → evaluate, then enter DONE (pkt_valid=1).
  - DONE: hold all pkt_* outputs stable. pkt_ack → IDLE, pkt_valid=0 next cycle.
- Evaluation at eop:
  - len err: token count≠2; handshake count≠0; data count<2; eop in PID state (SYNC only).
  - crc err: token CRC5 residual ≠ 5'b01100, or data CRC16 residual ≠ 16'h800D. Checked only when len ok.
- CRC form: each byte fed LSB-first, 8 bits per cycle.
  - CRC5: poly 5'b00101, init 5'b11111.
  - CRC16: poly 16'h8005, init 16'hFFFF.
  - Per bit d: fb = d ^ msb; reg = (reg<<1) ^ (fb ? poly : 0).
- Simultaneous rx_ready and rx_eop: byte is processed first, then eop is evaluated, in the same cycle.
- rx_eop in IDLE is ignored.
- Traffic while in DONE: bytes are ignored and not written. The eop of such a packet pulses dropped. The pending result and buffer are unchanged.
- pkt_ack asserted outside DONE is ignored.
- Reset mid-packet: immediate return to IDLE, outputs 0, partial packet lost.
- Buffer: simple dual-port RAM, write from BODY, read via rd_addr at any time. Contents at or above pkt_len are undefined.

Decomposition:
- usb.vh (shared): `SYNC_BYTE; PID codes (ACK_PID, NAK_PID, DATA0 etc.); PID class constants; CRC5/CRC16 polys, inits and residuals; pkt_err bit indices.
- Sub-module usb_crc_step: combinational, one byte in, next CRC5 and CRC16 out. Reused later by the TX framer.

Test Plan:
- SYNC, 8'hD2 (ACK), eop → pkt_valid=1, pid=4'h2, len=0, err=0; after ack, pkt_valid=0.
- SYNC, 8'h69, 8'h00, 8'h10, eop (IN addr0 ep0) → pid=4'h9, len=2, err=0, buffer {00,10}. Repeat with last byte 8'h11 → err=5'b01000 (crc).
- SYNC, C3 80 06 00 01 00 00 40 00 DD 94, eop → pid=4'h3, len=10, err=0, rd_data of addr 0..9 matches. Flip 8'h94→8'h95 → crc err.
- SYNC, 8'hD3, eop → err pid bit set. Byte 8'h55 in place of SYNC → sync err. SYNC, 8'h5A, 8'h00, eop → len err.
- DATA0 with 70 post-PID bytes → ovf set, len=66.
- Packet while pending → dropped pulses one cycle, first packet intact. Byte and eop in same cycle → byte counted. rst_n low mid-BODY → outputs 0, next packet decoded correctly.
